// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive buffer: entry layout and capture FSM states.
package uart_rx_fifo_pkg;

    localparam int DATA_W   = 8;
    localparam int PERR_BIT = 8;
    localparam int FERR_BIT = 9;
    localparam int ENTRY_W  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } cap_state_t;

    // Packs one received character into the stored entry format.
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic              ferr,
        input logic              perr,
        input logic [DATA_W-1:0] data
    );
        return {ferr, perr, data};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with show-ahead head output, occupancy count, full and empty.
module uart_sync_fifo #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_pop;

    assign empty   = (r_count == '0);
    assign full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign count   = r_count;
    assign w_pop   = rd_en && !empty;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: drains engine characters into a FIFO, acknowledges with READS,
// and keeps sticky overrun status for the host.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX_RDY,
    input  logic [7:0]        UART_RDATA,
    input  logic              PERR,
    input  logic              FERR,
    input  logic              OVF,
    output logic              READS,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_perr,
    output logic              rd_ferr,
    output logic              rx_empty,
    output logic              rx_full,
    output logic [ADDR_W:0]   rx_count,
    output logic              eng_ovf,
    output logic              fifo_ovf,
    input  logic              clr_status
);

    cap_state_t         r_state;
    cap_state_t         w_state_nxt;
    logic               r_reads;
    logic               r_eng_ovf;
    logic               r_fifo_ovf;
    logic               w_cap;
    logic               w_pop;
    logic               w_wr_ok;
    logic               w_wr_en;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_head;

    // Capture decision: next state, write strobe and drop detection.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (RX_RDY) begin
                    w_cap       = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign w_pop   = rd_en && !rx_empty;
    assign w_wr_ok = !rx_full || w_pop;
    assign w_wr_en = w_cap && w_wr_ok;
    assign w_drop  = w_cap && !w_wr_ok;

    // FSM state register and registered READS acknowledge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_reads <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_reads <= w_cap;
        end
    end

    // Sticky status flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_eng_ovf  <= 1'b0;
            r_fifo_ovf <= 1'b0;
        end else begin
            if (OVF) begin
                r_eng_ovf <= 1'b1;
            end else if (clr_status) begin
                r_eng_ovf <= 1'b0;
            end
            if (w_drop) begin
                r_fifo_ovf <= 1'b1;
            end else if (clr_status) begin
                r_fifo_ovf <= 1'b0;
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_data (pack_entry(FERR, PERR, UART_RDATA)),
        .rd_en   (rd_en),
        .rd_data (w_head),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign READS    = r_reads;
    assign eng_ovf  = r_eng_ovf;
    assign fifo_ovf = r_fifo_ovf;
    assign rd_data  = w_head[DATA_W-1:0];
    assign rd_perr  = w_head[PERR_BIT];
    assign rd_ferr  = w_head[FERR_BIT];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo using an expected-entry scoreboard.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              RX_RDY = 1'b0;
    logic [7:0]        UART_RDATA = '0;
    logic              PERR = 1'b0;
    logic              FERR = 1'b0;
    logic              OVF = 1'b0;
    logic              READS;
    logic              rd_en = 1'b0;
    logic [7:0]        rd_data;
    logic              rd_perr;
    logic              rd_ferr;
    logic              rx_empty;
    logic              rx_full;
    logic [ADDR_W:0]   rx_count;
    logic              eng_ovf;
    logic              fifo_ovf;
    logic              clr_status = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Scoreboard: {ferr, perr, data} of entries expected in the FIFO.
    logic [9:0] sb_q[$];
    int         m_count = 0;
    logic       m_fifo_ovf = 1'b0;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_RDY     (RX_RDY),
        .UART_RDATA (UART_RDATA),
        .PERR       (PERR),
        .FERR       (FERR),
        .OVF        (OVF),
        .READS      (READS),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_perr    (rd_perr),
        .rd_ferr    (rd_ferr),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .rx_count   (rx_count),
        .eng_ovf    (eng_ovf),
        .fifo_ovf   (fifo_ovf),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Engine model: raise RX_RDY, expect READS one cycle later, clear RX_RDY during ACK.
    task automatic send_char(input logic [7:0] d, input logic pe, input logic fe);
        bit was_empty;
        was_empty  = (m_count == 0);
        @(negedge clk);
        RX_RDY     = 1'b1;
        UART_RDATA = d;
        PERR       = pe;
        FERR       = fe;
        @(negedge clk);
        chk("reads_hi", READS, 1);
        if (m_count < DEPTH) begin
            sb_q.push_back({fe, pe, d});
            m_count++;
            if (was_empty) chk("head_latency", rd_data, d);
        end else begin
            m_fifo_ovf = 1'b1;
        end
        RX_RDY = 1'b0;
        PERR   = 1'b0;
        FERR   = 1'b0;
        @(negedge clk);
        chk("reads_lo", READS, 0);
    endtask

    // Host pop: compare head against the scoreboard, then pulse rd_en for one cycle.
    task automatic pop_one();
        logic [9:0] e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("pop_sb_nonempty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("pop_data", rd_data, e[7:0]);
            chk("pop_perr", rd_perr, e[8]);
            chk("pop_ferr", rd_ferr, e[9]);
            m_count--;
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clear_status();
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        m_fifo_ovf = 1'b0;
    endtask

    initial begin
        logic [9:0] e;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_reads", READS, 0);
        chk("rst_empty", rx_empty, 1);
        chk("rst_full", rx_full, 0);
        chk("rst_count", rx_count, 0);
        chk("rst_eng_ovf", eng_ovf, 0);
        chk("rst_fifo_ovf", fifo_ovf, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_perr", rd_perr, 0);
        chk("rst_rd_ferr", rd_ferr, 0);

        // Single character
        send_char(8'hA5, 1'b0, 1'b0);
        chk("single_count", rx_count, 1);
        chk("single_empty", rx_empty, 0);
        pop_one();
        chk("single_empty_after", rx_empty, 1);
        chk("single_data_after", rd_data, 0);

        // Error tagging
        send_char(8'h3C, 1'b1, 1'b0);
        send_char(8'h7E, 1'b0, 1'b1);
        chk("err_head_perr", rd_perr, 1);
        chk("err_head_ferr", rd_ferr, 0);
        pop_one();
        chk("err_next_perr", rd_perr, 0);
        chk("err_next_ferr", rd_ferr, 1);
        pop_one();

        // Fill and overflow
        for (int i = 0; i < DEPTH; i++) send_char(8'(i), 1'b0, 1'b0);
        chk("fill_full", rx_full, 1);
        chk("fill_count", rx_count, DEPTH);
        chk("fill_fifo_ovf_pre", fifo_ovf, 0);
        send_char(8'hFF, 1'b0, 1'b0);
        chk("fill_fifo_ovf", fifo_ovf, m_fifo_ovf);
        chk("fill_count_after_drop", rx_count, DEPTH);
        for (int i = 0; i < DEPTH; i++) pop_one();
        chk("drain_empty", rx_empty, 1);
        clear_status();
        chk("fifo_ovf_cleared", fifo_ovf, 0);

        // Full with simultaneous pop
        for (int i = 0; i < DEPTH; i++) send_char(8'h80 + 8'(i), 1'b0, 1'b0);
        chk("sim_full", rx_full, 1);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("sim_pop_data", rd_data, e[7:0]);
        sb_q.push_back({2'b00, 8'h55});
        RX_RDY     = 1'b1;
        UART_RDATA = 8'h55;
        rd_en      = 1'b1;
        @(negedge clk);
        rd_en  = 1'b0;
        RX_RDY = 1'b0;
        chk("sim_reads", READS, 1);
        @(negedge clk);
        chk("sim_count", rx_count, DEPTH);
        chk("sim_fifo_ovf", fifo_ovf, 0);
        chk("sim_full_after", rx_full, 1);
        for (int i = 0; i < DEPTH; i++) pop_one();
        chk("sim_drain_empty", rx_empty, 1);

        // Sticky and clear
        @(negedge clk);
        OVF = 1'b1;
        @(negedge clk);
        OVF = 1'b0;
        chk("eng_ovf_set", eng_ovf, 1);
        OVF        = 1'b1;
        clr_status = 1'b1;
        @(negedge clk);
        OVF        = 1'b0;
        clr_status = 1'b0;
        chk("eng_ovf_set_wins", eng_ovf, 1);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        chk("eng_ovf_cleared", eng_ovf, 0);

        // Reset mid-handshake with 3 entries held
        for (int i = 0; i < 3; i++) send_char(8'h10 + 8'(i), 1'b0, 1'b0);
        chk("mid_count_pre", rx_count, 3);
        @(negedge clk);
        RX_RDY     = 1'b1;
        UART_RDATA = 8'hEE;
        OVF        = 1'b1;
        @(negedge clk);
        chk("mid_in_ack", READS, 1);
        rst    = 1'b0;
        RX_RDY = 1'b0;
        OVF    = 1'b0;
        @(negedge clk);
        chk("mid_reads", READS, 0);
        chk("mid_count", rx_count, 0);
        chk("mid_empty", rx_empty, 1);
        chk("mid_eng_ovf", eng_ovf, 0);
        chk("mid_fifo_ovf", fifo_ovf, 0);
        rst = 1'b1;
        sb_q.delete();
        m_count    = 0;
        m_fifo_ovf = 1'b0;

        // Underflow: rd_en while empty changes nothing
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("uf_count", rx_count, 0);
        chk("uf_empty", rx_empty, 1);
        chk("uf_full", rx_full, 0);
        send_char(8'hB7, 1'b1, 1'b1);
        chk("uf_after_count", rx_count, 1);
        pop_one();
        chk("uf_after_empty", rx_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receive engine.
- Drains each completed character (RX_RDY, UART_RDATA, PERR, FERR, OVF) into a FIFO and returns a one-cycle READS pulse to the engine, which clears its ready flag and error flags.
- Presents a show-ahead read port plus sticky status to the host/register interface.
- Decouples host read latency from serial character time.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-low reset; sampled on the clk rising edge; 0 = reset.
- RX_RDY  in  1  engine character-ready flag; stays high until the engine samples READS.
- UART_RDATA  in  8  engine right-justified data.
- PERR  in  1  engine parity-error flag for the current character.
- FERR  in  1  engine framing-error flag for the current character.
- OVF  in  1  engine overrun flag.
- READS  out  1  registered one-cycle acknowledge to the engine.
- rd_en  in  1  host pops the head entry.
- rd_data  out  8  head data; show-ahead; 0 when empty.
- rd_perr  out  1  parity error of the head entry; 0 when empty.
- rd_ferr  out  1  framing error of the head entry; 0 when empty.
- rx_empty  out  1  FIFO empty.
- rx_full  out  1  FIFO full.
- rx_count  out  ADDR_W+1  number of entries held, 0..DEPTH.
- eng_ovf  out  1  sticky: engine OVF was seen high.
- fifo_ovf  out  1  sticky: a character was dropped because the FIFO was full.
- clr_status  in  1  clears eng_ovf and fifo_ovf.

Behaviour:
- Reset (rst=0 at an edge):
  - Capture FSM goes to IDLE; pointers and count go to 0.
  - READS=0, rx_empty=1, rx_full=0, eng_ovf=0, fifo_ovf=0.
  - rd_data, rd_perr and rd_ferr read 0.
  - Memory contents are don't-care.
  - Reset asserted mid-handshake abandons any pending capture; no entry is written.
- Capture FSM states:
  - IDLE:
    - If RX_RDY=1 at the edge: write {FERR, PERR, UART_RDATA} at wr_ptr (subject to the full rule below), set READS<=1, go to ACK.
    - Otherwise stay in IDLE.
  - ACK:
    - READS is high for exactly this cycle; the engine clears RX_RDY at this cycle's end edge.
    - On the edge: READS<=0, go to IDLE unconditionally; no capture occurs in ACK.
    - Guarantees one entry per character. A new character can be captured 2 cycles after the previous one.
- Full rule:
  - Write is accepted if rx_full=0, or if rd_en=1 with the FIFO non-empty on the same edge (the pop frees a slot).
  - Otherwise the character is dropped, fifo_ovf<=1, and READS is still pulsed so the engine is drained.
- eng_ovf:
  - Set on any edge where OVF=1, independent of FSM state.
  - OVF is also captured into eng_ovf during ACK, before the engine clears it.
- Read side:
  - rd_en with rx_empty=0 advances rd_ptr at the edge.
  - rd_en with rx_empty=1 is ignored; no underflow and no state change.
  - Head data is valid combinationally from mem[rd_ptr].
- Simultaneous write and read: both occur and rx_count is unchanged.
- Pointers are ADDR_W bits and wrap from DEPTH-1 to 0.
- rx_count:
  - +1 on write only, -1 on read only.
  - rx_empty = (rx_count==0); rx_full = (rx_count==DEPTH).
- Sticky status:
  - clr_status clears eng_ovf and fifo_ovf.
  - A set event on the same edge as clr_status wins; the flag stays 1.
- Latency:
  - RX_RDY sampled high → entry visible on rd_data 1 cycle later.
  - RX_RDY sampled high → READS high 1 cycle later.

Decomposition:
- Shared UART package:
  - Entry field positions: DATA [7:0], PERR bit 8, FERR bit 9; entry width 10.
  - Capture FSM state encodings: IDLE=1'b0, ACK=1'b1.
- One sub-module: uart_sync_fifo (generic 10-bit wide, DEPTH-deep synchronous FIFO with count/full/empty).
- uart_rx_fifo holds the capture FSM, READS generation, full/drop logic and the sticky flags.

Test Plan:
- Single character:
  - Stimulus: RX_RDY=1 with UART_RDATA=8'hA5, PERR=0, FERR=0.
  - Required: READS high exactly one cycle, starting 1 cycle after RX_RDY is sampled; rd_data=8'hA5; rx_count=1; rx_empty=0.
  - Then rd_en for one cycle → rx_empty=1, rd_data=0.
- Error tagging:
  - Stimulus: character 8'h3C with PERR=1, FERR=0, followed by 8'h7E with FERR=1.
  - Required: head rd_perr=1, rd_ferr=0; after one pop, rd_perr=0, rd_ferr=1.
- Fill and overflow:
  - Stimulus: 16 characters 8'h00..8'h0F with no reads, then character 8'hFF.
  - Required: rx_full=1; fifo_ovf=1; READS still pulsed for 8'hFF; draining yields 8'h00..8'h0F in order; 8'hFF is absent.
- Full with simultaneous pop:
  - Stimulus: FIFO full; rd_en=1 on the same edge a new character 8'h55 is captured.
  - Required: no drop; rx_count stays 16; fifo_ovf=0; 8'h55 is the last entry.
- Sticky and clear:
  - Stimulus: OVF=1 for one cycle; later clr_status=1 on the same edge OVF=1; then clr_status=1 alone.
  - Required: eng_ovf=1 after the first event; stays 1 after the simultaneous clear; 0 after the lone clr_status.
- Reset mid-handshake:
  - Stimulus: rst=0 asserted during ACK, with 3 entries held.
  - Required: next cycle READS=0, rx_count=0, rx_empty=1, eng_ovf=0, fifo_ovf=0.
  - Underflow check: rd_en while empty → no change.
